clock_divider_bank: RTL and testbench

//  Derives three divided clocks from one reference clock: fixed /2, parameterised even /N and odd /M.
//  All three run at 50% duty cycle.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_mod_counter.sv | 45 ++++
 rtl/clock_divider_bank.sv | 163 ++++++++++++++++
 tb/tb_clock_divider_bank.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the clock divider bank
//
// Contents:
//   MIN_DIV_EVEN / MIN_DIV_ODD : smallest legal divide ratios
//   cnt_width(n)               : counter width for a modulo-n count, never below 1
//   max_int(a, b)              : larger of two integers (lock threshold)
package clk_div_pkg;

  localparam int MIN_DIV_EVEN = 2;
  localparam int MIN_DIV_ODD  = 3;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_div_mod_counter.sv
// rtl/clk_div_mod_counter.sv - modulo-MOD up counter with wrap flag
//
// Ports:
//   clk_i   in   reference clock (posedge)
//   rst_i   in   asynchronous active-high reset, clears the count
//   cnt_o   out  current count, 0..MOD-1
//   wrap_o  out  high while the count sits at MOD-1 (next posedge returns to 0)
module clk_div_mod_counter
  import clk_div_pkg::*;
#(
  parameter  int MOD = 2,
  localparam int W   = cnt_width(MOD)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // With MOD == 1 the count is pinned at 0 and wrap_o is permanently high.
  assign wrap_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (wrap_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - fixed /2, even /DIVISOR_EVEN and odd /DIVISOR_ODD clock dividers
//
// Optional feature macro: CLKDIV_LOCK_EN (adds the `locked` output and its lock counter)
//
// Ports:
//   clk                  in   reference clock; posedge everywhere, negedge for the odd half-cycle flop
//   rst                  in   asynchronous active-high reset, clears every flop
//   clk_out_divide_by_2  out  clk/2, 50% duty
//   clk_out_even         out  clk/DIVISOR_EVEN, 50% duty
//   clk_out_odd          out  clk/DIVISOR_ODD, 50% duty (OR of posedge and negedge flops)
//   locked               out  CLKDIV_LOCK_EN only: sticky 1 from posedge max(DIVISOR_EVEN, DIVISOR_ODD)
module clock_divider_bank
  import clk_div_pkg::*;
#(
  parameter int DIVISOR_EVEN = 6,
  parameter int DIVISOR_ODD  = 5
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out_divide_by_2,
  output logic clk_out_even,
`ifdef CLKDIV_LOCK_EN
  output logic clk_out_odd,
  output logic locked
`else
  output logic clk_out_odd
`endif
);

  localparam int EVEN_HALF = DIVISOR_EVEN / 2;
  localparam int EVEN_W    = cnt_width(EVEN_HALF);
  localparam int ODD_W     = cnt_width(DIVISOR_ODD);

  // The posedge flop of the odd path is high for counts below this value;
  // the negedge copy stretches the high phase by the extra half cycle.
  localparam logic [ODD_W-1:0] ODD_HI = ODD_W'((DIVISOR_ODD - 1) / 2);

  // Parameter legality.
  if (DIVISOR_EVEN < MIN_DIV_EVEN || (DIVISOR_EVEN % 2) != 0) begin : g_bad_even
    $error("clock_divider_bank: DIVISOR_EVEN must be even and >= 2");
  end
  if (DIVISOR_ODD < MIN_DIV_ODD || (DIVISOR_ODD % 2) != 1) begin : g_bad_odd
    $error("clock_divider_bank: DIVISOR_ODD must be odd and >= 3");
  end

  // /2 path: bare toggle flop.
  logic div2_q;
  logic div2_d;

  assign div2_d = ~div2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div2_q <= 1'b0;
    end else begin
      div2_q <= div2_d;
    end
  end

  // Even path: toggle once every EVEN_HALF posedges.
  logic [EVEN_W-1:0] even_cnt;
  logic              even_wrap;
  logic              even_q;
  logic              even_d;

  clk_div_mod_counter #(
    .MOD (EVEN_HALF)
  ) u_even_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .cnt_o  (even_cnt),
    .wrap_o (even_wrap)
  );

  assign even_d = even_q ^ even_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      even_q <= 1'b0;
    end else begin
      even_q <= even_d;
    end
  end

  // Odd path: modulo-DIVISOR_ODD count drives a posedge flop; a negedge
  // copy delays its falling edge by half a clock so the OR is 50% duty.
  logic [ODD_W-1:0] odd_cnt;
  logic             odd_wrap;
  logic             odd_pos_q;
  logic             odd_pos_d;
  logic             odd_neg_q;

  clk_div_mod_counter #(
    .MOD (DIVISOR_ODD)
  ) u_odd_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .cnt_o  (odd_cnt),
    .wrap_o (odd_wrap)
  );

  assign odd_pos_d = (odd_cnt < ODD_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odd_pos_q <= 1'b0;
    end else begin
      odd_pos_q <= odd_pos_d;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      odd_neg_q <= 1'b0;
    end else begin
      odd_neg_q <= odd_pos_q;
    end
  end

  // Only the wrap of the even counter and the count of the odd counter matter.
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{even_cnt, odd_wrap};

  assign clk_out_divide_by_2 = div2_q;
  assign clk_out_even        = even_q;
  assign clk_out_odd         = odd_pos_q | odd_neg_q;

`ifdef CLKDIV_LOCK_EN
  // Saturating posedge counter: reaches LOCK_N-1 after LOCK_N-1 edges, so
  // locked rises on posedge LOCK_N and stays up until the next reset.
  localparam int                LOCK_N    = max_int(DIVISOR_EVEN, DIVISOR_ODD);
  localparam int                LOCK_W    = cnt_width(LOCK_N);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_N - 1);

  logic [LOCK_W-1:0] lock_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_d;
  logic              locked_q;
  logic              locked_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (lock_cnt_q == LOCK_LAST) begin
      locked_d = 1'b1;
    end else begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`endif

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - self-checking bench for clock_divider_bank
`timescale 1ns/100ps
module tb_clock_divider_bank;

  logic clk;
  logic rst;

  logic a_d2, a_ev, a_od;
  logic b_d2, b_ev, b_od;
  logic c_d2, c_ev, c_od;
`ifdef CLKDIV_LOCK_EN
  logic a_lk, b_lk, c_lk;
`endif

  int tests;
  int fails;
  int k;  // posedges since last reset release

  clock_divider_bank #(.DIVISOR_EVEN(6), .DIVISOR_ODD(5)) dut_a (
    .clk                 (clk),
    .rst                 (rst),
    .clk_out_divide_by_2 (a_d2),
    .clk_out_even        (a_ev),
`ifdef CLKDIV_LOCK_EN
    .clk_out_odd         (a_od),
    .locked              (a_lk)
`else
    .clk_out_odd         (a_od)
`endif
  );

  clock_divider_bank #(.DIVISOR_EVEN(2), .DIVISOR_ODD(3)) dut_b (
    .clk                 (clk),
    .rst                 (rst),
    .clk_out_divide_by_2 (b_d2),
    .clk_out_even        (b_ev),
`ifdef CLKDIV_LOCK_EN
    .clk_out_odd         (b_od),
    .locked              (b_lk)
`else
    .clk_out_odd         (b_od)
`endif
  );

  clock_divider_bank #(.DIVISOR_EVEN(8), .DIVISOR_ODD(7)) dut_c (
    .clk                 (clk),
    .rst                 (rst),
    .clk_out_divide_by_2 (c_d2),
    .clk_out_even        (c_ev),
`ifdef CLKDIV_LOCK_EN
    .clk_out_odd         (c_od),
    .locked              (c_lk)
`else
    .clk_out_odd         (c_od)
`endif
  );

  // Posedges at 10, 20, 30 ...; negedges at 5, 15, 25 ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Reference model in terms of posedge count k and half-cycle phase.
  function automatic logic exp_div2(input int kk);
    return (kk >= 1) && ((kk % 2) == 1);
  endfunction

  function automatic logic exp_even(input int kk, input int e);
    int half;
    half = e / 2;
    return (kk >= 1) && (((kk / half) % 2) == 1);
  endfunction

  // Half-cycle h = 0 right after posedge 1; high for the first m half-cycles of each 2m.
  function automatic logic exp_odd(input int kk, input int ph, input int m);
    int h;
    if (kk < 1) return 1'b0;
    h = 2 * (kk - 1) + ph;
    return (h % (2 * m)) < m;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s k=%0d t=%0t observed=%b expected=%b", tag, k, $time, obs, exp);
    end
  endtask

  task automatic check_all(input int ph);
    chk("a_div2", a_d2, exp_div2(k));
    chk("a_even", a_ev, exp_even(k, 6));
    chk("a_odd",  a_od, exp_odd(k, ph, 5));
    chk("b_div2", b_d2, exp_div2(k));
    chk("b_even", b_ev, exp_even(k, 2));
    chk("b_odd",  b_od, exp_odd(k, ph, 3));
    chk("c_div2", c_d2, exp_div2(k));
    chk("c_even", c_ev, exp_even(k, 8));
    chk("c_odd",  c_od, exp_odd(k, ph, 7));
`ifdef CLKDIV_LOCK_EN
    chk("a_lock", a_lk, k >= 6);
    chk("b_lock", b_lk, k >= 3);
    chk("c_lock", c_lk, k >= 8);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, a_d2 | a_ev | a_od, 1'b0);
    chk({tag, "_b"}, b_d2 | b_ev | b_od, 1'b0);
    chk({tag, "_c"}, c_d2 | c_ev | c_od, 1'b0);
`ifdef CLKDIV_LOCK_EN
    chk({tag, "_lock"}, a_lk | b_lk | c_lk, 1'b0);
`endif
  endtask

  task automatic step_pos();
    @(posedge clk);
    #1;
    k++;
    check_all(0);
  endtask

  task automatic step_neg();
    @(negedge clk);
    #1;
    check_all(1);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      step_pos();
      step_neg();
    end
  endtask

  // Called 1 ns after a posedge; len avoids landing the release on any clk edge.
  task automatic pulse_reset(input int len);
    rst = 1'b1;
    #1;
    check_zero("in_pulse");
    #(len - 1);
    rst = 1'b0;
    k = 0;
    check_zero("post_release");
  endtask

  initial begin
    int lens[5];
    bit found;
    tests = 0;
    fails = 0;
    k     = 0;
    rst   = 1'b1;
    lens  = '{2, 3, 5, 6, 7};

    // Reset held across clock activity.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("hold_p");
      @(negedge clk);
      #1;
      check_zero("hold_n");
    end
    #1;
    rst = 1'b0;
    check_zero("release");

    run_cycles(40);

    // Mid-run reset while the /5 output is high, 7 ns pulse.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_pos();
      if (a_od === 1'b1) found = 1'b1;
    end
    chk("odd_high_wait", found, 1'b1);
    pulse_reset(7);
    run_cycles(25);

    // Randomised run lengths and reset pulses.
    for (int r = 0; r < 10; r++) begin
      run_cycles($urandom_range(1, 30));
      step_pos();
      pulse_reset(lens[$urandom_range(0, 4)]);
    end
    run_cycles(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
